// File: rtl/operand_sel_pipe.sv
// N-way operand selector feeding a 1- or 2-deep pipeline register chain with
// stall hold, flush-to-bubble and illegal-select flagging on the delivered word.
module operand_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int ONEHOT = 0,
    parameter int STAGES = 1,
    localparam int SEL_W = (ONEHOT != 0) ? NUM_IN : ((NUM_IN > 2) ? $clog2(NUM_IN) : 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_sel_err
);

    // Flow control: a word enters stage 1 on every edge unless stall or flush is
    // high; flush beats stall and empties every stage; stall freezes every stage.
    // Data moves regardless of in_valid, so out_data is only meaningful with out_valid.

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("operand_sel_pipe: NUM_IN=%0d outside 2..16", NUM_IN);
    end
    if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
        $error("operand_sel_pipe: STAGES=%0d must be 1 or 2", STAGES);
    end

    logic [WIDTH-1:0] dec_data;
    logic             sel_ok;

    if (ONEHOT != 0) begin : g_onehot
        always_comb begin
            dec_data = '0;
            sel_ok   = (in_sel != '0) && ((in_sel & (in_sel - SEL_W'(1))) == '0);
            for (int k = 0; k < NUM_IN; k++) begin
                if (in_sel[k]) dec_data = in_data[k*WIDTH +: WIDTH];
            end
            // Never let a multi-hot select OR inputs together.
            if (!sel_ok) dec_data = '0;
        end
    end else begin : g_binary
        always_comb begin
            dec_data = '0;
            sel_ok   = int'(in_sel) < NUM_IN;
            for (int k = 0; k < NUM_IN; k++) begin
                if (int'(in_sel) == k) dec_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    logic [WIDTH-1:0] s1_data_d;
    logic             s1_valid_d;
    logic             s1_err_d;

    assign s1_data_d  = dec_data;
    assign s1_valid_d = in_valid;
    assign s1_err_d   = in_valid & ~sel_ok;

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
            valid_q <= '0;
            err_q   <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
            valid_q <= '0;
            err_q   <= '0;
        end else if (!stall) begin
            data_q[0]  <= s1_data_d;
            valid_q[0] <= s1_valid_d;
            err_q[0]   <= s1_err_d;
            for (int i = 1; i < STAGES; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign out_data    = data_q[STAGES-1];
    assign out_valid   = valid_q[STAGES-1];
    assign out_sel_err = err_q[STAGES-1];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe: four configurations (binary 1- and 2-stage,
// binary with 3 inputs, one-hot) driven from a vector table plus hand-written sequences.
module tb_operand_sel_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    localparam logic [31:0] W0 = 32'h11111111;
    localparam logic [31:0] W1 = 32'h22222222;
    localparam logic [31:0] W2 = 32'h33333333;
    localparam logic [31:0] W3 = 32'h44444444;

    logic [127:0] data4;
    logic [95:0]  data3;
    assign data4 = {W3, W2, W1, W0};
    assign data3 = {W2, W1, W0};

    // u_b1: 4-in binary 1-stage; u_b2: 4-in binary 2-stage; u_b3: 3-in binary; u_oh: one-hot
    logic [1:0]  sel_b1 = '0, sel_b2 = '0, sel_b3 = '0;
    logic [3:0]  sel_oh = '0;
    logic        v_b1 = 0, v_b2 = 0, v_b3 = 0, v_oh = 0;
    logic [31:0] d_b1, d_b2, d_b3, d_oh;
    logic        ov_b1, ov_b2, ov_b3, ov_oh;
    logic        oe_b1, oe_b2, oe_b3, oe_oh;
    logic        st_b2 = 0, fl_b2 = 0;

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(4), .ONEHOT(0), .STAGES(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_data(data4), .in_sel(sel_b1), .in_valid(v_b1),
        .stall(stall), .flush(flush), .out_data(d_b1), .out_valid(ov_b1), .out_sel_err(oe_b1));

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(4), .ONEHOT(0), .STAGES(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .in_data(data4), .in_sel(sel_b2), .in_valid(v_b2),
        .stall(st_b2), .flush(fl_b2), .out_data(d_b2), .out_valid(ov_b2), .out_sel_err(oe_b2));

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0), .STAGES(1)) u_b3 (
        .clk(clk), .rst_n(rst_n), .in_data(data3), .in_sel(sel_b3), .in_valid(v_b3),
        .stall(stall), .flush(flush), .out_data(d_b3), .out_valid(ov_b3), .out_sel_err(oe_b3));

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(4), .ONEHOT(1), .STAGES(1)) u_oh (
        .clk(clk), .rst_n(rst_n), .in_data(data4), .in_sel(sel_oh), .in_valid(v_oh),
        .stall(stall), .flush(flush), .out_data(d_oh), .out_valid(ov_oh), .out_sel_err(oe_oh));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          dut;
        logic [3:0]  sel;
        logic        valid;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    logic [31:0] exp_q [$];

    initial begin
        // dut: 0=u_b1, 1=u_b3, 2=u_oh
        vecs[0]  = '{0, 4'd2,    1'b1, W2,    1'b1, 1'b0};
        vecs[1]  = '{0, 4'd0,    1'b1, W0,    1'b1, 1'b0};
        vecs[2]  = '{0, 4'd3,    1'b1, W3,    1'b1, 1'b0};
        vecs[3]  = '{0, 4'd1,    1'b0, W1,    1'b0, 1'b0};
        vecs[4]  = '{1, 4'd3,    1'b1, 32'h0, 1'b1, 1'b1};
        vecs[5]  = '{1, 4'd3,    1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{1, 4'd1,    1'b1, W1,    1'b1, 1'b0};
        vecs[7]  = '{2, 4'b0100, 1'b1, W2,    1'b1, 1'b0};
        vecs[8]  = '{2, 4'b0110, 1'b1, 32'h0, 1'b1, 1'b1};
        vecs[9]  = '{2, 4'b0000, 1'b1, 32'h0, 1'b1, 1'b1};
        vecs[10] = '{2, 4'b1000, 1'b1, W3,    1'b1, 1'b0};
        vecs[11] = '{2, 4'b0001, 1'b0, W0,    1'b0, 1'b0};

        // Reset state before any clock capture
        #2;
        check("rst_b1_data", d_b1, 32'h0);
        check("rst_b1_valid", 32'(ov_b1), 32'h0);
        check("rst_b2_valid", 32'(ov_b2), 32'h0);
        check("rst_oh_err", 32'(oe_oh), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-stage vectors
        for (int i = 0; i < NVEC; i++) begin
            logic [31:0] ad;
            logic        av, ae;
            v_b1 = 0; v_b3 = 0; v_oh = 0;
            case (vecs[i].dut)
                0: begin sel_b1 = vecs[i].sel[1:0]; v_b1 = vecs[i].valid; end
                1: begin sel_b3 = vecs[i].sel[1:0]; v_b3 = vecs[i].valid; end
                default: begin sel_oh = vecs[i].sel; v_oh = vecs[i].valid; end
            endcase
            tick();
            case (vecs[i].dut)
                0: begin ad = d_b1; av = ov_b1; ae = oe_b1; end
                1: begin ad = d_b3; av = ov_b3; ae = oe_b3; end
                default: begin ad = d_oh; av = ov_oh; ae = oe_oh; end
            endcase
            check($sformatf("vec%0d_data", i), ad, vecs[i].exp_data);
            check($sformatf("vec%0d_valid", i), 32'(av), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err", i), 32'(ae), 32'(vecs[i].exp_err));
        end
        v_b1 = 0; v_b3 = 0; v_oh = 0;

        // Two-stage: sel 0..3 back to back, each word appears two edges later, no gaps
        exp_q = {W0, W1, W2, W3};
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                sel_b2 = 2'(c);
                v_b2   = 1'b1;
            end else begin
                v_b2 = 1'b0;
            end
            tick();
            if (c == 0) begin
                check("s2_first_edge_valid", 32'(ov_b2), 32'h0);
            end else begin
                check($sformatf("s2_seq%0d_data", c - 1), d_b2, exp_q.pop_front());
                check($sformatf("s2_seq%0d_valid", c - 1), 32'(ov_b2), 32'h1);
            end
        end

        // Stall: W1 in stage 2, W2 in stage 1, hold three edges then resume
        sel_b2 = 2'd1; v_b2 = 1'b1; tick();
        sel_b2 = 2'd2; tick();
        check("pre_stall_data", d_b2, W1);
        sel_b2 = 2'd0; st_b2 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d_data", c), d_b2, W1);
            check($sformatf("stall%0d_valid", c), 32'(ov_b2), 32'h1);
        end
        st_b2 = 1'b0; tick();
        check("resume_data", d_b2, W2);

        // Stall and flush together: flush wins, both stages emptied
        st_b2 = 1'b1; fl_b2 = 1'b1; tick();
        check("flush_valid", 32'(ov_b2), 32'h0);
        check("flush_data", d_b2, 32'h0);
        st_b2 = 1'b0; fl_b2 = 1'b0; v_b2 = 1'b0; tick();
        check("flush_s1_empty_valid", 32'(ov_b2), 32'h0);

        // Asynchronous reset mid-cycle
        sel_b2 = 2'd3; v_b2 = 1'b1; sel_b1 = 2'd2; v_b1 = 1'b1;
        tick(); tick();
        check("pre_rst_b2_valid", 32'(ov_b2), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_b2_data", d_b2, 32'h0);
        check("async_rst_b2_valid", 32'(ov_b2), 32'h0);
        check("async_rst_b1_valid", 32'(ov_b1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_b1_data", d_b1, W2);
        check("post_rst_b2_edge1_valid", 32'(ov_b2), 32'h0);
        tick();
        check("post_rst_b2_edge2_data", d_b2, W3);
        check("post_rst_b2_edge2_valid", 32'(ov_b2), 32'h1);
        check("post_rst_b2_edge2_err", 32'(oe_b2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
